gb_subbus_bridge: RTL

- Parametrised bridge that hangs NCHAN child ghostbuses off one parent ghostbus.
- Each child owns a 2^CAW-word window at a configurable base address.
- Decodes each parent access and drives the selected child with a trimmed address: upper AW-CAW bits are zero.
- Registers the request and returns child read data on the parent bus at a fixed, pipelined latency. Successor to the hand-rolled single-child glue.

---
 rtl/gb_subbus_bridge.sv | 123 ++++++++++++
 1 files changed

// File: rtl/gb_subbus_bridge.sv
// Ghostbus bridge: decodes parent accesses into NCHAN child windows, pipelined read return.
// Optional decode-miss flag and miss pattern enabled by `define GB_BRIDGE_DECERR_EN.
module gb_subbus_bridge #(
    parameter int                   AW        = 24,
    parameter int                   DW        = 32,
    parameter int                   NCHAN     = 2,
    parameter int                   CAW       = 8,
    parameter logic [NCHAN*AW-1:0]  BASE_ADDR = {24'h000100, 24'h000000},
    parameter int                   CHILD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [AW-1:0]       p_addr,
    input  logic [DW-1:0]       p_wdata,
    input  logic                p_wstb,
    output logic [DW-1:0]       p_rdata,
    output logic [AW-1:0]       c_addr,
    output logic [DW-1:0]       c_wdata,
    output logic [NCHAN-1:0]    c_wstb,
    output logic [NCHAN-1:0]    c_sel,
    input  logic [NCHAN*DW-1:0] c_rdata,
    output logic                dec_err,
    input  logic                dec_err_clr
);

    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

`ifdef GB_BRIDGE_DECERR_EN
    localparam logic [DW-1:0] MISS_DATA = DW'(32'hDEC0DEAD);
`else
    localparam logic [DW-1:0] MISS_DATA = '0;
`endif

    typedef struct packed {
        logic          rd;
        logic [CW-1:0] ch;
        logic          miss;
    } tag_t;

    logic [NCHAN-1:0] hit;
    logic [NCHAN-1:0] sel;
    logic [CW-1:0]    idx;
    logic             miss;
    tag_t             tag_q;
    tag_t             tag_al;
    logic [DW-1:0]    rdata_d;

    // Descending scan so the lowest matching channel wins on overlap.
    always_comb begin
        hit = '0;
        sel = '0;
        idx = '0;
        for (int k = NCHAN - 1; k >= 0; k--) begin
            hit[k] = (p_addr[AW-1:CAW] == BASE_ADDR[k*AW+CAW +: AW-CAW]);
            if (hit[k]) begin
                sel    = '0;
                sel[k] = 1'b1;
                idx    = CW'(k);
            end
        end
        miss = ~|hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_addr  <= '0;
            c_wdata <= '0;
            c_wstb  <= '0;
            c_sel   <= '0;
            tag_q   <= '0;
        end else begin
            c_addr  <= {{(AW-CAW){1'b0}}, p_addr[CAW-1:0]};
            c_wdata <= p_wdata;
            c_wstb  <= {NCHAN{p_wstb}} & sel;
            c_sel   <= sel;
            tag_q   <= '{rd: ~p_wstb, ch: idx, miss: miss};
        end
    end

    // Tag delay matches the child read latency so it lines up with c_rdata.
    generate
        if (CHILD_LAT == 0) begin : g_nolat
            assign tag_al = tag_q;
        end else begin : g_lat
            tag_t sr [CHILD_LAT];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < CHILD_LAT; i++) sr[i] <= '0;
                end else begin
                    sr[0] <= tag_q;
                    for (int i = 1; i < CHILD_LAT; i++) sr[i] <= sr[i-1];
                end
            end
            assign tag_al = sr[CHILD_LAT-1];
        end
    endgenerate

    always_comb begin
        rdata_d = '0;
        if (tag_al.rd) begin
            if (tag_al.miss) rdata_d = MISS_DATA;
            else             rdata_d = c_rdata[tag_al.ch*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) p_rdata <= '0;
        else     p_rdata <= rdata_d;
    end

`ifdef GB_BRIDGE_DECERR_EN
    always_ff @(posedge clk) begin
        if (rst)              dec_err <= 1'b0;
        else if (miss)        dec_err <= 1'b1;
        else if (dec_err_clr) dec_err <= 1'b0;
    end
`else
    logic unused_dec_err_clr;
    assign unused_dec_err_clr = dec_err_clr;
    assign dec_err = 1'b0;
`endif

endmodule
